bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter W_IN, 20, binary input width; matches display data bus.
REQ-002 Parameter N_DIG, 6, BCD digit count; matches six-digit display.
REQ-003 sys_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 sys_rst  in  1  reset; synchronous, active-high.
REQ-005 in_valid  in  1  in_data valid.
REQ-006 in_ready  out  1  block can accept a value.
REQ-007 in_data  in  W_IN  unsigned binary value.
REQ-008 out_valid  out  1  result valid.
REQ-009 out_ready  in  1  consumer accepts result.
REQ-010 out_bcd  out  4*N_DIG  packed BCD; [3:0] = units digit.
REQ-011 out_lead  out  N_DIG  significance mask; bit i = 1 if digit i is at or below the most-significant non-zero digit.
REQ-012 out_ovf  out  1  input exceeded 999999 and was saturated.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CONV and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE.
REQ-015 out_valid SHALL be 1 only in DONE.
REQ-016 In IDLE, in_valid=1 SHALL capture in_data, clear the BCD shift register, load the iteration counter with W_IN and move to CONV.
REQ-017 At capture, a value above 999999 SHALL be replaced by 999999, and the overflow flag SHALL be set.
REQ-018 Each CONV cycle SHALL perform one double-dabble iteration: add 3 to every BCD digit >= 5, then shift {bcd, bin} left by one.
REQ-019 The counter SHALL decrement once per CONV cycle.
REQ-020 The iteration in which the counter reaches 0 SHALL transfer the result to the output registers and move to DONE.
REQ-021 Latency SHALL be fixed: out_valid rises exactly W_IN cycles after the accepting edge (20 cycles).
REQ-022 out_bcd, out_lead and out_ovf SHALL come from dedicated output registers that hold the last result through IDLE and CONV until the next transfer.
REQ-023 The internal shift register SHALL never drive the outputs.
REQ-024 out_lead SHALL be computed at transfer; bit 0 SHALL always be 1, so a value of 0 gives 000001.
REQ-025 Interior zero digits SHALL be marked significant.
REQ-026 In DONE, out_ready=1 SHALL move the FSM to IDLE.
REQ-027 The FSM SHALL not accept new input in that same cycle; minimum throughput is one conversion per W_IN+2 cycles.
REQ-028 In DONE with out_ready=0, all outputs SHALL remain stable indefinitely.
REQ-029 in_valid SHALL be ignored outside IDLE, with no capture.
REQ-030 Out-of-range iteration counts SHALL be unreachable: the counter width is ceil(log2(W_IN+1)).

Reset
REQ-031 sys_rst=1 at a clock edge SHALL force IDLE from any state, including mid-CONV or DONE; any in-flight conversion is discarded.
REQ-032 Reset values SHALL be: in_ready=1 (the cycle after reset), out_valid=0, out_bcd=0, out_lead=000001, out_ovf=0, counter=0, shift register=0.
REQ-033 While sys_rst=1, in_valid SHALL be ignored.

Structure
REQ-034 Package bin2bcd_pkg SHALL hold W_IN, N_DIG, the constant SAT_MAX=999999 and the state enum type.
REQ-035 Sub-module bcd_digit_adj SHALL be the combinational 4-bit "add 3 if >=5" cell, instantiated N_DIG times.
REQ-036 This block SHALL feed the six-digit 74HC595 display driver.
REQ-037 The driver's data and point/sign generation SHALL remain outside this block.

Verification
REQ-038 Zero: after reset, in_data=0 -> out_bcd=0x000000, out_lead=000001, out_ovf=0, out_valid exactly 20 cycles after accept.
REQ-039 Full range: 123456 -> 0x123456 with lead 111111; 405 -> 0x000405 with lead 000111.
REQ-040 Saturation: 999999 -> 0x999999 with ovf=0; 1000000 -> 0x999999 with ovf=1; 0xFFFFF -> 0x999999 with ovf=1.
REQ-041 Backpressure: out_ready=0 for 10 cycles in DONE -> outputs unchanged and in_ready=0 throughout; then out_ready=1 -> IDLE next cycle, and a following 7 converts to 0x000007.
REQ-042 Mid-conversion reset: sys_rst pulsed in the 7th CONV cycle -> next cycle out_valid=0, in_ready=1, out_bcd=0; a new input of 42 then yields 0x000042.
REQ-043 Ignored input: in_valid held high during CONV with changing in_data -> only the originally accepted value appears on out_bcd.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared constants and the FSM state type for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  // Binary input width, sized to the display data bus.
  localparam int W_IN = 20;

  // Number of BCD digits on the six-digit display.
  localparam int N_DIG = 6;

  // Largest value the display can show; larger inputs saturate here.
  localparam int unsigned SAT_MAX = 999999;

  // Conversion FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: one BCD digit, add 3 when the digit is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Pre-shift correction so the following left shift carries into the next digit.
  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle) feeding a
// six-digit display driver. Results live in dedicated output registers.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// in_ready is 1 only in IDLE, out_valid is 1 only in DONE; out_bcd/out_lead/out_ovf
// hold the last result until the next conversion completes.
module bin2bcd_seq #(
  parameter int W_IN  = bin2bcd_pkg::W_IN,
  parameter int N_DIG = bin2bcd_pkg::N_DIG
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W_IN-1:0]        in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*N_DIG-1:0]     out_bcd,
  output logic [N_DIG-1:0]       out_lead,
  output logic                   out_ovf,
  output bin2bcd_pkg::state_t    state
);

  import bin2bcd_pkg::*;

  localparam int CNT_W = $clog2(W_IN + 1);
  localparam logic [N_DIG-1:0] LEAD_RST = {{(N_DIG-1){1'b0}}, 1'b1};

  logic [4*N_DIG-1:0] bcd_q;
  logic [W_IN-1:0]    bin_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;

  logic [4*N_DIG-1:0] bcd_adj;
  logic [4*N_DIG-1:0] bcd_next;
  logic [W_IN-1:0]    bin_next;
  logic [N_DIG-1:0]   lead_next;
  logic               sat_hit;
  logic               seen;

  // One correction cell per digit.
  for (genvar g = 0; g < N_DIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d(bcd_q[4*g +: 4]),
      .q(bcd_adj[4*g +: 4])
    );
  end

  // Shift {bcd, bin} left by one after correction; the top corrected bit falls off
  // and is always zero because the input is saturated to six digits.
  assign bcd_next = (4*N_DIG)'({bcd_adj, bin_q[W_IN-1]});
  assign bin_next = {bin_q[W_IN-2:0], 1'b0};

  // Inputs above the display range are clamped at capture.
  assign sat_hit = (32'(in_data) > SAT_MAX);

  // Significance mask: every digit at or below the highest non-zero digit, units always on.
  always_comb begin
    seen      = 1'b0;
    lead_next = '0;
    for (int i = N_DIG - 1; i >= 0; i--) begin
      seen         = seen | (bcd_next[4*i +: 4] != 4'd0);
      lead_next[i] = seen;
    end
    lead_next[0] = 1'b1;
  end

  // Conversion FSM with registered handshake and result outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_bcd   <= '0;
      out_lead  <= LEAD_RST;
      out_ovf   <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      bin_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_q    <= sat_hit ? W_IN'(SAT_MAX) : in_data;
            ovf_q    <= sat_hit;
            bcd_q    <= '0;
            cnt_q    <= CNT_W'(W_IN);
            in_ready <= 1'b0;
            state    <= CONV;
          end
        end
        CONV: begin
          bcd_q <= bcd_next;
          bin_q <= bin_next;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            out_bcd   <= bcd_next;
            out_lead  <= lead_next;
            out_ovf   <= ovf_q;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Back to IDLE only; a new value is taken on a later edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed corner values plus random values,
// compared against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

  import bin2bcd_pkg::*;

  localparam int TW  = W_IN;
  localparam int TD  = N_DIG;
  localparam int LAT = W_IN;

  logic              sys_clk;
  logic              sys_rst;
  logic              in_valid;
  logic              in_ready;
  logic [TW-1:0]     in_data;
  logic              out_valid;
  logic              out_ready;
  logic [4*TD-1:0]   out_bcd;
  logic [TD-1:0]     out_lead;
  logic              out_ovf;
  state_t            dbg_state;

  int n_checks;
  int n_fail;

  logic [4*TD-1:0] exp_q[$];
  logic [TD-1:0]   lead_q[$];
  logic            ovf_q[$];

  bin2bcd_seq #(.W_IN(TW), .N_DIG(TD)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bcd  (out_bcd),
    .out_lead (out_lead),
    .out_ovf  (out_ovf),
    .state    (dbg_state)
  );

  // Clock and reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: decimal digits of the saturated value.
  function automatic logic [4*TD-1:0] model_bcd(input int unsigned v);
    int unsigned s;
    logic [4*TD-1:0] r;
    s = (v > 999999) ? 999999 : v;
    r = '0;
    for (int i = 0; i < TD; i++) begin
      r[4*i +: 4] = 4'(s % 10);
      s = s / 10;
    end
    return r;
  endfunction

  function automatic logic [TD-1:0] model_lead(input int unsigned v);
    int unsigned s;
    int nd;
    s = (v > 999999) ? 999999 : v;
    nd = 1;
    while (s >= 10) begin
      s = s / 10;
      nd++;
    end
    return TD'((1 << nd) - 1);
  endfunction

  // Drivers
  task automatic push_expect(input int unsigned v);
    exp_q.push_back(model_bcd(v));
    lead_q.push_back(model_lead(v));
    ovf_q.push_back(v > 999999);
  endtask

  // Full transaction: offer v, wait for result, check, hold DONE for `hold` cycles, release.
  task automatic convert(input int unsigned v, input int hold, input bit junk);
    int n;
    logic [4*TD-1:0] eb;
    logic [TD-1:0]   el;
    logic            eo;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge sys_clk); #1;
      n++;
    end
    check("in_ready_before", 32'(in_ready), 32'd1);
    push_expect(v);
    in_valid = 1'b1;
    in_data  = TW'(v);
    @(posedge sys_clk); #1;
    if (!junk) in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      if (junk) in_data = TW'($urandom_range(0, (1 << TW) - 1));
      @(posedge sys_clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("latency", 32'(n), 32'(LAT));
    eb = exp_q.pop_front();
    el = lead_q.pop_front();
    eo = ovf_q.pop_front();
    check("bcd", 32'(out_bcd), 32'(eb));
    check("lead", 32'(out_lead), 32'(el));
    check("ovf", 32'(out_ovf), 32'(eo));
    check("in_ready_done", 32'(in_ready), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge sys_clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_bcd", 32'(out_bcd), 32'(eb));
      check("hold_lead", 32'(out_lead), 32'(el));
      check("hold_ovf", 32'(out_ovf), 32'(eo));
    end
    out_ready = 1'b1;
    @(posedge sys_clk); #1;
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready), 32'd1);
    check("idle_bcd_held", 32'(out_bcd), 32'(eb));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_bcd"}, 32'(out_bcd), 32'd0);
    check({tag, "_lead"}, 32'(out_lead), 32'd1);
    check({tag, "_ovf"}, 32'(out_ovf), 32'd0);
  endtask

  // Stimulus
  initial begin
    int unsigned v;
    n_checks  = 0;
    n_fail    = 0;
    sys_rst   = 1'b1;
    in_valid  = 1'b1;
    in_data   = TW'(1234);
    out_ready = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst  = 1'b0;
    in_valid = 1'b0;
    check_reset_outputs("reset");
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    @(posedge sys_clk); #1;
    check("rst_ignored_ready", 32'(in_ready), 32'd1);

    convert(0, 0, 1'b0);
    convert(123456, 0, 1'b0);
    convert(405, 0, 1'b0);
    convert(999999, 0, 1'b0);
    convert(1000000, 0, 1'b0);
    convert(20'hFFFFF, 0, 1'b0);
    convert(31337, 10, 1'b0);
    convert(7, 0, 1'b0);

    // Reset pulsed in the 7th conversion cycle.
    in_valid = 1'b1;
    in_data  = TW'(654321);
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    check_reset_outputs("midrst");
    convert(42, 0, 1'b0);

    // in_valid held high with changing data during conversion.
    convert(808, 0, 1'b1);

    for (int t = 0; t < 20; t++) begin
      if (t % 4 == 0) v = $urandom_range(1000000, (1 << TW) - 1);
      else v = $urandom_range(0, 999999);
      convert(v, $urandom_range(0, 3), 1'(t % 3 == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
